// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer and its register file.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_WIDTH  = 8;
  localparam int APB_DATA_WIDTH  = 32;
  localparam int APB_MEM_DEPTH   = 64;
  localparam int APB_WAIT_CYCLES = 2;

  // A transfer errors when it is not word aligned or lands past the last word.
  function automatic logic decodeError(input logic [1:0] byteOffset,
                                       input logic [31:0] wordIndex,
                                       input int unsigned depth);
    return (byteOffset != 2'b00) || (wordIndex >= depth);
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Word-organised register file with byte-strobed writes and a registered read port.
module apb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64,
  parameter int IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        wIdx_i,
  input  logic [DATA_WIDTH-1:0]   wData_i,
  input  logic [DATA_WIDTH/8-1:0] wStrb_i,
  input  logic                    re_i,
  input  logic                    rZero_i,
  input  logic [IDX_W-1:0]        rIdx_i,
  output logic [DATA_WIDTH-1:0]   rData_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rData_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wStrb_i[b]) begin
          mem_q[wIdx_i][8*b +: 8] <= wData_i[8*b +: 8];
        end
      end
    end
  end

  // Read data holds between completions; an errored read returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rData_q <= '0;
    end else if (re_i) begin
      rData_q <= rZero_i ? '0 : mem_q[rIdx_i];
    end
  end

  assign rData_o = rData_q;

endmodule

// File: rtl/apb_slave.sv
// APB completer in front of apb_regfile. Define APB_SLAVE_WAIT_EN to build the
// WAIT state and its wait-state counter (WAIT_CYCLES per transfer).
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH  = APB_DATA_WIDTH,
  parameter int MEM_DEPTH   = APB_MEM_DEPTH,
  parameter int WAIT_CYCLES = APB_WAIT_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr
);

  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  isWrite_q, isWrite_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  pready_q, pslverr_q;
`ifdef APB_SLAVE_WAIT_EN
  logic [3:0]            cnt_q, cnt_d;
`endif

  logic setupPhase;
  logic enterDone;
  logic errCur;
  logic errNext;
  logic memWe;
  logic memRe;

  assign setupPhase = psel & ~penable;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    isWrite_d = isWrite_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
`ifdef APB_SLAVE_WAIT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (setupPhase) begin
          addr_d    = paddr;
          isWrite_d = pwrite;
          wdata_d   = pwdata;
          strb_d    = pstrb;
`ifdef APB_SLAVE_WAIT_EN
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
`ifdef APB_SLAVE_WAIT_EN
      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Entering DONE can coincide with the setup latch, so decode the incoming address too.
  assign errCur    = decodeError(addr_q[1:0], 32'(addr_q[ADDR_WIDTH-1:2]), MEM_DEPTH);
  assign errNext   = decodeError(addr_d[1:0], 32'(addr_d[ADDR_WIDTH-1:2]), MEM_DEPTH);
  assign enterDone = (state_d == DONE);
  assign memRe     = enterDone & ~isWrite_d;
  assign memWe     = (state_q == DONE) & psel & penable & isWrite_q & ~errCur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      isWrite_q <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      isWrite_q <= isWrite_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= enterDone;
      pslverr_q <= enterDone & errNext;
`ifdef APB_SLAVE_WAIT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  apb_regfile #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (memWe),
    .wIdx_i (IDX_W'(addr_q[ADDR_WIDTH-1:2])),
    .wData_i(wdata_q),
    .wStrb_i(strb_q),
    .re_i   (memRe),
    .rZero_i(errNext),
    .rIdx_i (IDX_W'(addr_d[ADDR_WIDTH-1:2])),
    .rData_o(prdata)
  );

  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
